// File: rtl/col_normalizer_if.sv
// Start/busy/done handshake and result bus for col_normalizer.
// COLNORM_RSQ_EN adds the raw sum-of-squares output out_rii_sq.
interface col_normalizer_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
);
  localparam int unsigned RW   = W + ($clog2(N) + 1) / 2;
  localparam int unsigned ACCW = 2 * RW;

  logic           start;
  logic [N*W-1:0] in_a;
  logic           busy;
  logic           done;
  logic [W-1:0]   out_rii;
  logic [N*W-1:0] out_q;
  logic           err_zero;
  logic           rii_sat;
`ifdef COLNORM_RSQ_EN
  logic [ACCW-1:0] out_rii_sq;
`endif

  modport master (
    output start, in_a,
    input  busy, done, out_rii, out_q, err_zero, rii_sat
`ifdef COLNORM_RSQ_EN
    , input out_rii_sq
`endif
  );

  modport slave (
    input  start, in_a,
    output busy, done, out_rii, out_q, err_zero, rii_sat
`ifdef COLNORM_RSQ_EN
    , output out_rii_sq
`endif
  );
endinterface

// File: rtl/col_normalizer.sv
// QR column normaliser: r = sqrt(sum a_i^2) by restoring sqrt, q_i = a_i / r by restoring division.
// Define COLNORM_RSQ_EN to also register and output the raw sum of squares (out_rii_sq).
module col_normalizer #(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 16,
  parameter int unsigned FRAC = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  col_normalizer_if.slave  bus
);
  localparam int unsigned RW      = W + ($clog2(N) + 1) / 2;
  localparam int unsigned ACCW    = 2 * RW;
  localparam int unsigned CntW    = $clog2(RW) + 1;
  localparam int unsigned ElemW   = $clog2(N);
  localparam int unsigned RemW    = RW + 1;  // sqrt remainder is bounded by 2*root
  localparam int unsigned AccIdxW = $clog2(ACCW);
  localparam int unsigned DvdW    = W + FRAC;
  localparam int unsigned DvdIdxW = $clog2(DvdW);

  typedef enum logic [2:0] {StIdle, StAcc, StSqrt, StDiv, StDone} state_e;

  state_e                state_q, state_d;
  logic [N*W-1:0]        a_q, a_d;
  logic [ACCW-1:0]       acc_q, acc_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ElemW-1:0]      elem_q, elem_d;
  logic [RW-1:0]         root_q, root_d;
  logic [RemW-1:0]       srem_q, srem_d;
  logic [RW-1:0]         drem_q, drem_d;
  logic [W-1:0]          quo_q, quo_d;
  logic [W-1:0]          qres_q [N];
  logic [W-1:0]          qres_d [N];
  logic [W-1:0]          out_q_q [N];
  logic [W-1:0]          out_q_d [N];
  logic [W-1:0]          out_rii_q, out_rii_d;
  logic                  err_zero_q, err_zero_d;
  logic                  rii_sat_q, rii_sat_d;
  logic [ACCW-1:0]       rsq_q, rsq_d;

  logic signed [W-1:0]   a_arr [N];
  logic signed [W-1:0]   a_k;
  logic signed [2*W-1:0] sq;
  logic [2*W-1:0]        sq_u;
  logic [W-1:0]          abs_a;
  logic [DvdW-1:0]       dvd;
  logic [DvdIdxW-1:0]    dvd_idx;
  logic [AccIdxW-1:0]    acc_idx;
  logic [RemW+1:0]       s_sh, s_trial;
  logic                  s_ge;
  logic [RW-1:0]         d_cur;
  logic [RW:0]           d_trial;
  logic                  d_ge;
  logic [W-1:0]          quo_cur, quo_nx, q_val;
  logic                  sat;

  for (genvar g = 0; g < N; g++) begin : g_lanes
    assign a_arr[g]              = a_q[g*W +: W];
    assign bus.out_q[g*W +: W]   = out_q_q[g];
  end

  assign bus.busy     = (state_q == StAcc) || (state_q == StSqrt) || (state_q == StDiv);
  assign bus.done     = (state_q == StDone);
  assign bus.out_rii  = out_rii_q;
  assign bus.err_zero = err_zero_q;
  assign bus.rii_sat  = rii_sat_q;
`ifdef COLNORM_RSQ_EN
  assign bus.out_rii_sq = rsq_q;
`endif

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    elem_d     = elem_q;
    root_d     = root_q;
    srem_d     = srem_q;
    drem_d     = drem_q;
    quo_d      = quo_q;
    qres_d     = qres_q;
    out_q_d    = out_q_q;
    out_rii_d  = out_rii_q;
    err_zero_d = err_zero_q;
    rii_sat_d  = rii_sat_q;
    rsq_d      = rsq_q;

    // The one multiplier squares the element selected by elem_q.
    a_k   = a_arr[elem_q];
    sq    = a_k * a_k;
    sq_u  = sq;
    abs_a = a_k[W-1] ? W'(-a_k) : W'(a_k);

    // Sqrt step: bring down the next radicand bit pair, MSB pair first.
    acc_idx = AccIdxW'(ACCW - 2 - 2 * int'(cnt_q));
    s_sh    = {srem_q, acc_q[acc_idx +: 2]};
    s_trial = {1'b0, root_q, 2'b01};
    s_ge    = (s_sh >= s_trial);

    // Division step: the top FRAC dividend bits preload the remainder, W bits are shifted in.
    dvd     = {abs_a, {FRAC{1'b0}}};
    dvd_idx = DvdIdxW'(W - 1 - int'(cnt_q));
    d_cur   = (cnt_q == '0) ? RW'(abs_a >> (W - FRAC)) : drem_q;
    d_trial = {d_cur, dvd[dvd_idx]};
    d_ge    = (d_trial >= {1'b0, root_q});
    quo_cur = (cnt_q == '0) ? '0 : quo_q;
    quo_nx  = W'({quo_cur, d_ge});
    q_val   = a_k[W-1] ? (~quo_nx + 1'b1) : quo_nx;

    sat = |root_q[RW-1:W];

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          a_d     = bus.in_a;
          acc_d   = '0;
          cnt_d   = '0;
          elem_d  = '0;
          root_d  = '0;
          srem_d  = '0;
          state_d = StAcc;
        end else begin
          state_d = StIdle;
        end
      end
      StAcc: begin
        acc_d = acc_q + ACCW'(sq_u);
        if (elem_q == ElemW'(N - 1)) begin
          elem_d  = '0;
          state_d = StSqrt;
        end else begin
          elem_d = elem_q + 1'b1;
        end
      end
      StSqrt: begin
        srem_d = s_ge ? RemW'(s_sh - s_trial) : RemW'(s_sh);
        root_d = RW'({root_q, s_ge});
        if (cnt_q == CntW'(RW - 1)) begin
          cnt_d = '0;
          if (acc_q == '0) begin
            out_q_d    = '{default: '0};
            out_rii_d  = '0;
            err_zero_d = 1'b1;
            rii_sat_d  = 1'b0;
            rsq_d      = acc_q;
            state_d    = StDone;
          end else begin
            state_d = StDiv;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDiv: begin
        drem_d = d_ge ? RW'(d_trial - {1'b0, root_q}) : RW'(d_trial);
        quo_d  = quo_nx;
        if (cnt_q == CntW'(W - 1)) begin
          cnt_d          = '0;
          qres_d[elem_q] = q_val;
          if (elem_q == ElemW'(N - 1)) begin
            out_q_d    = qres_d;
            out_rii_d  = sat ? '1 : root_q[W-1:0];
            rii_sat_d  = sat;
            err_zero_d = 1'b0;
            rsq_d      = acc_q;
            state_d    = StDone;
          end else begin
            elem_d = elem_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      elem_q     <= '0;
      root_q     <= '0;
      srem_q     <= '0;
      drem_q     <= '0;
      quo_q      <= '0;
      qres_q     <= '{default: '0};
      out_q_q    <= '{default: '0};
      out_rii_q  <= '0;
      err_zero_q <= 1'b0;
      rii_sat_q  <= 1'b0;
      rsq_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      elem_q     <= elem_d;
      root_q     <= root_d;
      srem_q     <= srem_d;
      drem_q     <= drem_d;
      quo_q      <= quo_d;
      qres_q     <= qres_d;
      out_q_q    <= out_q_d;
      out_rii_q  <= out_rii_d;
      err_zero_q <= err_zero_d;
      rii_sat_q  <= rii_sat_d;
      rsq_q      <= rsq_d;
    end
  end

endmodule

// File: tb/tb_col_normalizer.sv
// Scoreboard bench for col_normalizer at N=4, W=16, FRAC=10.
module tb_col_normalizer;
  typedef struct {
    logic [15:0] rii;
    logic [63:0] q;
    logic        err;
    logic        sat;
    logic [33:0] rsq;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [15:0] last_rii;

  col_normalizer_if #(.N(4), .W(16)) bus ();

  col_normalizer #(.N(4), .W(16), .FRAC(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [63:0] v);
    exp_t   e;
    longint acc = 0;
    longint r = 0;
    longint a, t, qq;
    for (int i = 0; i < 4; i++) begin
      a = longint'($signed(v[i*16 +: 16]));
      acc += a * a;
    end
    for (int b = 20; b >= 0; b--) begin
      t = r + (longint'(1) << b);
      if (t * t <= acc) r = t;
    end
    e.rsq = 34'(acc);
    e.q   = '0;
    if (acc == 0) begin
      e.rii = '0; e.err = 1'b1; e.sat = 1'b0; e.lat = 21;
    end else begin
      e.err = 1'b0;
      e.sat = (r > 65535);
      e.rii = e.sat ? 16'hFFFF : 16'(r);
      e.lat = 85;
      for (int i = 0; i < 4; i++) begin
        a  = longint'($signed(v[i*16 +: 16]));
        qq = ((a < 0 ? -a : a) * 1024) / r;
        if (a < 0) qq = -qq;
        e.q[i*16 +: 16] = 16'(qq);
      end
    end
    return e;
  endfunction

  task automatic start_col(input logic [63:0] v);
    bus.in_a  = v;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges until done is seen; -1 if it never comes.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.start = 1'b0; bus.in_a = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.err_zero, bus.rii_sat} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000",
                         {bus.busy, bus.done, bus.err_zero, bus.rii_sat});
    end
    checks++;
    if (bus.out_rii !== 16'd0 || bus.out_q !== 64'd0) begin
      errors++; $display("FAIL reset_outputs got rii=%0d q=%h want 0", bus.out_rii, bus.out_q);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_vectors;
    logic [63:0] vecs [8];
    exp_t e;
    int   n;
    vecs[0] = {16'd0, 16'd0, 16'd4096, 16'd3072};
    vecs[1] = {16'd0, 16'd0, 16'd4096, 16'hF400};
    vecs[2] = {4{16'h7FFF}};
    vecs[3] = {4{16'h8000}};
    vecs[4] = '0;
    for (int i = 5; i < 8; i++) vecs[i] = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) begin
      sb.push_back(model(vecs[i]));
      start_col(vecs[i]);
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++; $display("FAIL vec%0d_busy got %b want 1", i, bus.busy);
      end
      wait_done(n);
      e = sb.pop_front();
      checks++;
      if (n != e.lat) begin
        errors++; $display("FAIL vec%0d_latency got %0d want %0d", i, n, e.lat);
      end
      checks++;
      if (bus.out_rii !== e.rii) begin
        errors++; $display("FAIL vec%0d_rii got %0d want %0d", i, bus.out_rii, e.rii);
      end
      checks++;
      if (bus.out_q !== e.q) begin
        errors++; $display("FAIL vec%0d_q got %h want %h", i, bus.out_q, e.q);
      end
      checks++;
      if ({bus.err_zero, bus.rii_sat, bus.busy} !== {e.err, e.sat, 1'b0}) begin
        errors++; $display("FAIL vec%0d_flags got %b want %b", i,
                           {bus.err_zero, bus.rii_sat, bus.busy}, {e.err, e.sat, 1'b0});
      end
`ifdef COLNORM_RSQ_EN
      checks++;
      if (bus.out_rii_sq !== e.rsq) begin
        errors++; $display("FAIL vec%0d_rsq got %0d want %0d", i, bus.out_rii_sq, e.rsq);
      end
`endif
      @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b0 || bus.out_rii !== e.rii) begin
        errors++; $display("FAIL vec%0d_after_done got done=%b rii=%0d want 0/%0d", i,
                           bus.done, bus.out_rii, e.rii);
      end
      last_rii = e.rii;
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] v1, v2;
    exp_t e;
    int   n;
    v1 = {16'd0, 16'd0, 16'd0, 16'd1024};
    v2 = {16'd0, 16'd0, 16'd4096, 16'd3072};
    sb.push_back(model(v1));
    start_col(v1);
    repeat (4) @(posedge clk);
    #1;
    bus.in_a = v2; bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b0; bus.in_a = {4{16'h1234}};
    checks++;
    if (bus.out_rii !== last_rii) begin
      errors++; $display("FAIL hold_during_run got %0d want %0d", bus.out_rii, last_rii);
    end
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n + 7 != e.lat) begin
      errors++; $display("FAIL ignore_latency got %0d want %0d", n + 7, e.lat);
    end
    checks++;
    if (bus.out_rii !== e.rii || bus.out_q !== e.q) begin
      errors++; $display("FAIL ignore_result got rii=%0d q=%h want %0d/%h",
                         bus.out_rii, bus.out_q, e.rii, e.q);
    end
    sb.push_back(model(v2));
    bus.in_a = v2; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL b2b_accept got busy=%b done=%b want 1/0", bus.busy, bus.done);
    end
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n != e.lat) begin
      errors++; $display("FAIL b2b_latency got %0d want %0d", n, e.lat);
    end
    checks++;
    if (bus.out_rii !== e.rii || bus.out_q !== e.q || bus.err_zero !== e.err) begin
      errors++; $display("FAIL b2b_result got rii=%0d q=%h want %0d/%h",
                         bus.out_rii, bus.out_q, e.rii, e.q);
    end
  endtask

  task automatic test_reset_midrun;
    logic [63:0] v;
    exp_t e;
    int   n;
    start_col({4{16'h7FFF}});
    repeat (39) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.err_zero, bus.rii_sat} !== 4'b0 ||
        bus.out_rii !== 16'd0 || bus.out_q !== 64'd0) begin
      errors++; $display("FAIL midrun_reset got busy=%b done=%b rii=%0d q=%h want all 0",
                         bus.busy, bus.done, bus.out_rii, bus.out_q);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    v = {16'd4000, -16'sd3000, 16'd2000, -16'sd1000};
    sb.push_back(model(v));
    start_col(v);
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n != e.lat) begin
      errors++; $display("FAIL post_reset_latency got %0d want %0d", n, e.lat);
    end
    checks++;
    if (bus.out_rii !== e.rii || bus.out_q !== e.q || bus.rii_sat !== e.sat) begin
      errors++; $display("FAIL post_reset_result got rii=%0d q=%h want %0d/%h",
                         bus.out_rii, bus.out_q, e.rii, e.q);
    end
  endtask

  initial begin
    last_rii = '0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_midrun();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_empty got %0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
